// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-requester shared-ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef logic req_id_t;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_EQ  = 1;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of the signals between the arbiter and the shared combinational ALU.
interface alu_share_arb_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CTRLSIG    = 1
);
    logic [CTRLSIG-1:0]    ctrl;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] out;
    logic                  eq;

    modport master (output ctrl, op1, op2, input out, eq);
    modport slave  (input ctrl, op1, op2, output out, eq);
endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the pointer.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters, one operation in flight.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CTRLSIG    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [CTRLSIG-1:0]    req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [CTRLSIG-1:0]    req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_eq,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_eq,
    input  logic                  rsp1_ready,
    output logic [CTRLSIG-1:0]    alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_eq
);

    state_e                state_q, state_d;
    req_id_t               ptr_q, ptr_d;
    req_id_t               owner_q, owner_d;
    logic [CTRLSIG-1:0]    ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  eq_q, eq_d;
    logic [1:0]            grant;
    logic                  idle;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign idle = (state_q == IDLE);

    // Reset gates only the ready outputs; flop inputs are already held by the async clear.
    assign req0_ready = idle & grant[0] & rst_n;
    assign req1_ready = idle & grant[1] & rst_n;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        eq_d       = eq_q;
        alu_ctrl   = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        rsp0_valid = 1'b0;
        rsp0_data  = '0;
        rsp0_eq    = 1'b0;
        rsp1_valid = 1'b0;
        rsp1_data  = '0;
        rsp1_eq    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = req_id_t'(grant[1]);
                    ctrl_d  = grant[1] ? req1_ctrl : req0_ctrl;
                    a_d     = grant[1] ? req1_a : req0_a;
                    b_d     = grant[1] ? req1_b : req0_b;
                    ptr_d   = req_id_t'(~grant[1]);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_ctrl = ctrl_q;
                alu_op1  = a_q;
                alu_op2  = b_q;
                res_d    = alu_out;
                eq_d     = alu_eq;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_q == 1'b0) begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = res_q;
                    rsp0_eq    = eq_q;
                    if (rsp0_ready) state_d = IDLE;
                end else begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = res_q;
                    rsp1_eq    = eq_q;
                    if (rsp1_ready) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            eq_q    <= eq_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: grant table, directed sequences, random traffic vs. model.
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [0:0]    req0_ctrl, req1_ctrl;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid, rsp0_eq, rsp1_eq;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rsp0_ready, rsp1_ready;

    alu_share_arb_if #(.DATA_WIDTH(DW), .CTRLSIG(1)) alu_bus ();

    assign alu_bus.out = (alu_bus.ctrl == 1'(OP_EQ)) ? '0 : DW'(alu_bus.op1 + alu_bus.op2);
    assign alu_bus.eq  = (alu_bus.ctrl == 1'(OP_EQ)) && (alu_bus.op1 == alu_bus.op2);

    alu_share_arb #(.DATA_WIDTH(DW), .CTRLSIG(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_eq    (rsp0_eq),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_eq    (rsp1_eq),
        .rsp1_ready (rsp1_ready),
        .alu_ctrl   (alu_bus.ctrl),
        .alu_op1    (alu_bus.op1),
        .alu_op2    (alu_bus.op2),
        .alu_out    (alu_bus.out),
        .alu_eq     (alu_bus.eq)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: age = cycles since the accepted request, -1 when free.
    int            age = -1;
    bit            ptr = 1'b0;
    bit            own = 1'b0;
    logic          lc;
    logic [DW-1:0] la, lb, res;
    logic          reseq;
    logic [1:0]    eg, last_hs;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [1:0] g_p0;
        logic [1:0] g_p1;
    } gvec_t;
    gvec_t gtab[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic          ec;
        logic [DW-1:0] eo1, eo2, ed0, ed1;
        logic [1:0]    erv, ee;
        #1;
        eg = '0; ec = 1'b0; eo1 = '0; eo2 = '0; ed0 = '0; ed1 = '0; erv = '0; ee = '0;
        if (rst_n) begin
            if (age < 0) begin
                if (req0_valid && req1_valid) eg = ptr ? 2'b10 : 2'b01;
                else eg = {req1_valid, req0_valid};
            end else if (age == 1) begin
                ec = lc; eo1 = la; eo2 = lb;
            end else begin
                erv[own] = 1'b1;
                ee[own]  = reseq;
                if (own) ed1 = res; else ed0 = res;
            end
        end
        chk("req0_ready", req0_ready, eg[0]);
        chk("req1_ready", req1_ready, eg[1]);
        chk("alu_ctrl",   alu_bus.ctrl, ec);
        chk("alu_op1",    alu_bus.op1, eo1);
        chk("alu_op2",    alu_bus.op2, eo2);
        chk("rsp0_valid", rsp0_valid, erv[0]);
        chk("rsp0_data",  rsp0_data, ed0);
        chk("rsp0_eq",    rsp0_eq, ee[0]);
        chk("rsp1_valid", rsp1_valid, erv[1]);
        chk("rsp1_data",  rsp1_data, ed1);
        chk("rsp1_eq",    rsp1_eq, ee[1]);
    endtask

    task automatic advance();
        @(posedge clk);
        last_hs = (rst_n && age < 0) ? eg : 2'b00;
        if (!rst_n) begin
            age = -1;
            ptr = 1'b0;
        end else if (age < 0) begin
            if (eg != 2'b00) begin
                own = eg[1];
                lc  = own ? req1_ctrl : req0_ctrl;
                la  = own ? req1_a : req0_a;
                lb  = own ? req1_b : req0_b;
                ptr = ~own;
                age = 1;
            end
        end else if (age == 1) begin
            res   = (lc == 1'(OP_ADD)) ? DW'(la + lb) : '0;
            reseq = (lc == 1'(OP_EQ)) && (la == lb);
            age   = 2;
        end else if ((!own && rsp0_ready) || (own && rsp1_ready)) begin
            age = -1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic set_req(input int n, input logic c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (n == 0) begin req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b; end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_gtab(input bit use_p1);
        for (int i = 0; i < 4; i++) begin
            req0_valid = gtab[i].v0;
            req1_valid = gtab[i].v1;
            #1;
            chk("gtab_ready", {req1_ready, req0_ready}, use_p1 ? gtab[i].g_p1 : gtab[i].g_p0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    bit            pend[2];
    logic          rc[2];
    logic [DW-1:0] ra[2], rb[2];

    initial begin
        gtab[0] = '{v0: 1'b0, v1: 1'b0, g_p0: 2'b00, g_p1: 2'b00};
        gtab[1] = '{v0: 1'b1, v1: 1'b0, g_p0: 2'b01, g_p1: 2'b01};
        gtab[2] = '{v0: 1'b0, v1: 1'b1, g_p0: 2'b10, g_p1: 2'b10};
        gtab[3] = '{v0: 1'b1, v1: 1'b1, g_p0: 2'b01, g_p1: 2'b10};

        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        // Reset with random inputs: everything must read zero.
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'(($urandom));  req1_valid = 1'(($urandom));
            req0_ctrl  = 1'($urandom);    req1_ctrl  = 1'($urandom);
            req0_a = DW'($urandom); req0_b = DW'($urandom);
            req1_a = DW'($urandom); req1_b = DW'($urandom);
            step();
        end
        clear_inputs();
        rst_n = 1'b1;

        // Grant table with pointer at 0.
        run_gtab(1'b0);
        step();

        // Single add: result two cycles after the handshake.
        set_req(0, 1'b0, 8'h05, 8'h03);
        sample();
        chk("add_hs", req0_ready, 1'b1);
        advance();
        req0_valid = 1'b0;
        sample();
        chk("add_t1_valid", rsp0_valid, 1'b0);
        advance();
        sample();
        chk("add_t2_valid", rsp0_valid, 1'b1);
        chk("add_data", rsp0_data, 8'h08);
        chk("add_eq", rsp0_eq, 1'b0);
        advance();

        // Grant table with pointer at 1 (req0 was just served).
        run_gtab(1'b1);
        step();

        // Contention right after reset: req0 first, then req1 compare.
        do_reset();
        set_req(0, 1'b0, 8'h10, 8'h20);
        set_req(1, 1'b1, 8'h2A, 8'h2A);
        sample();
        chk("cont_first", {req1_ready, req0_ready}, 2'b01);
        advance();
        req0_valid = 1'b0;
        step();
        sample();
        chk("cont_rsp0", rsp0_valid, 1'b1);
        advance();
        sample();
        chk("cont_second", req1_ready, 1'b1);
        advance();
        req1_valid = 1'b0;
        step();
        sample();
        chk("cont_rsp1_eq", rsp1_eq, 1'b1);
        chk("cont_rsp1_data", rsp1_data, 8'h00);
        advance();

        // Wrap-around add.
        set_req(1, 1'b0, 8'hFF, 8'h01);
        step();
        req1_valid = 1'b0;
        step();
        sample();
        chk("wrap_data", rsp1_data, 8'h00);
        chk("wrap_eq", rsp1_eq, 1'b0);
        advance();

        // Backpressure on rsp0 while req1 waits.
        set_req(0, 1'b0, 8'h11, 8'h22);
        set_req(1, 1'b0, 8'h03, 8'h04);
        rsp0_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("bp_hold_data", rsp0_data, 8'h33);
            chk("bp_req1_ready", req1_ready, 1'b0);
            advance();
        end
        rsp0_ready = 1'b1;
        step();
        sample();
        chk("bp_req1_grant", req1_ready, 1'b1);
        advance();
        req1_valid = 1'b0;
        step();
        sample();
        chk("bp_rsp1_data", rsp1_data, 8'h07);
        advance();

        // Reset during EXEC: outputs clear at once, no response afterwards.
        set_req(0, 1'b0, 8'h01, 8'h02);
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        sample();
        chk("midrst_alu", alu_bus.op1, 8'h00);
        advance();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("midrst_no_rsp", rsp0_valid, 1'b0);
            advance();
        end

        // Random traffic against the model.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(2) == 0) begin
                    pend[n] = 1'b1;
                    rc[n] = 1'($urandom_range(1));
                    ra[n] = ($urandom_range(3) == 0) ? 8'hFF : DW'($urandom);
                    rb[n] = ($urandom_range(1) == 0) ? ra[n] : DW'($urandom);
                end else if (pend[n] && $urandom_range(15) == 0) begin
                    pend[n] = 1'b0;
                end
            end
            req0_valid = pend[0]; req0_ctrl = rc[0]; req0_a = ra[0]; req0_b = rb[0];
            req1_valid = pend[1]; req1_ctrl = rc[1]; req1_a = ra[1]; req1_b = rb[1];
            rsp0_ready = 1'($urandom_range(1));
            rsp1_ready = 1'($urandom_range(1));
            step();
            if (last_hs[0]) pend[0] = 1'b0;
            if (last_hs[1]) pend[1] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
